// File: rtl/hub75_pkg.sv
// Shared constants for the HUB75 panel path: scan states, pixel-pair bit layout
// and default panel geometry used by the scan controller and the LED output stage.
package hub75_pkg;

   localparam int unsigned COLS_DEF   = 32;
   localparam int unsigned ROWS_DEF   = 8;
   localparam int unsigned ADDR_W_DEF = 3;
   localparam int unsigned DIV_DEF    = 6;
   localparam int unsigned PIX_W      = 6;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SHIFT_LO = 3'd1;
   localparam logic [2:0] ST_SHIFT_HI = 3'd2;
   localparam logic [2:0] ST_BLANK    = 3'd3;
   localparam logic [2:0] ST_LATCH    = 3'd4;

   // Bit positions inside a {R1,G1,B1,R2,G2,B2} pixel pair
   localparam int unsigned R1_BIT = 5;
   localparam int unsigned G1_BIT = 4;
   localparam int unsigned B1_BIT = 3;
   localparam int unsigned R2_BIT = 2;
   localparam int unsigned G2_BIT = 1;
   localparam int unsigned B2_BIT = 0;

endpackage

// File: rtl/hub75_phase_div.sv
// Panel-clock phase divider: counts DIV system cycles per phase and flags the
// last cycle of each phase; clr holds the count at zero while the scan is idle.
module hub75_phase_div
   import hub75_pkg::*;
#(
   parameter int unsigned DIV  = DIV_DEF,
   parameter int unsigned PH_W = $clog2(DIV) + 1
) (
   input  logic            Clkin,
   input  logic            Rstin,
   input  logic            clr,
   output logic [PH_W-1:0] phase,
   output logic            phase_end_c
);

   logic [PH_W-1:0] phase_q;
   logic [PH_W-1:0] phase_d;

   always_comb begin
      phase_end_c = (phase_q == PH_W'(DIV - 1));
      phase_d     = phase_q + PH_W'(1);
      if (clr || phase_end_c) begin
         phase_d = '0;
      end
   end

   always_ff @(posedge Clkin) begin
      if (Rstin) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row-scan controller: fetches pixel pairs, shifts them out with the panel
// clock, then blanks and latches each row. Define SCAN_TESTPAT_EN for an internal test pattern.
module hub75_scan_ctrl
   import hub75_pkg::*;
#(
   parameter int unsigned COLS   = COLS_DEF,
   parameter int unsigned ROWS   = ROWS_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DIV    = DIV_DEF,
   parameter int unsigned COL_W  = $clog2(COLS)
) (
   input  logic                    Clkin,
   input  logic                    Rstin,
   input  logic                    en,
   output logic [ADDR_W+COL_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]        rd_data,
   output logic                    R1,
   output logic                    G1,
   output logic                    B1,
   output logic                    R2,
   output logic                    G2,
   output logic                    B2,
   output logic                    Clk,
   output logic                    Lat,
   output logic                    OE,
   output logic                    A,
   output logic                    B,
   output logic                    C,
   output logic                    frame_start
);

   localparam int unsigned PH_W = $clog2(DIV) + 1;

   logic [2:0]              state_q, state_d;
   logic [COL_W-1:0]        col_q, col_d;
   logic [ADDR_W-1:0]       row_q, row_d;
   logic                    shown_q, shown_d;
   logic [ADDR_W+COL_W-1:0] rd_addr_q, rd_addr_d;
   logic [PIX_W-1:0]        pix_q, pix_d;
   logic                    clk_q, clk_d;
   logic                    lat_q, lat_d;
   logic                    oe_q, oe_d;
   logic [ADDR_W-1:0]       abc_q, abc_d;
   logic                    fs_q, fs_d;
   logic [PH_W-1:0]         phase;
   logic                    phase_end_c;
   logic                    clr_c;
   logic                    shifting_c;
   logic                    latch_entry_c;
   logic [PIX_W-1:0]        pix_c;

   assign clr_c = (state_q == ST_IDLE);

   hub75_phase_div #(
      .DIV  (DIV),
      .PH_W (PH_W)
   ) u_phase_div (
      .Clkin       (Clkin),
      .Rstin       (Rstin),
      .clr         (clr_c),
      .phase       (phase),
      .phase_end_c (phase_end_c)
   );

   // Pixel source for the column being fetched
`ifdef SCAN_TESTPAT_EN
   always_comb begin
      pix_c         = '0;
      pix_c[R1_BIT] = col_q[0];
      pix_c[R2_BIT] = col_q[0];
      pix_c[G1_BIT] = row_q[0];
      pix_c[G2_BIT] = row_q[0];
      pix_c[B1_BIT] = (col_q == COL_W'(row_q));
      pix_c[B2_BIT] = (col_q == COL_W'(row_q));
   end
`else
   assign pix_c = rd_data;
`endif

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      shown_d = shown_q;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_SHIFT_LO;
               col_d   = '0;
            end
         end
         ST_SHIFT_LO: begin
            if (phase_end_c) state_d = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (phase_end_c) begin
               if (col_q == COL_W'(COLS - 1)) begin
                  state_d = ST_BLANK;
               end else begin
                  col_d   = col_q + COL_W'(1);
                  state_d = ST_SHIFT_LO;
               end
            end
         end
         ST_BLANK: begin
            if (phase_end_c) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            if (phase_end_c) begin
               row_d   = (row_q == ADDR_W'(ROWS - 1)) ? '0 : row_q + ADDR_W'(1);
               shown_d = 1'b1;
               col_d   = '0;
               state_d = en ? ST_SHIFT_LO : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Panel outputs are registered so they line up with the state they belong to
      shifting_c    = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI);
      latch_entry_c = (state_q == ST_BLANK) && phase_end_c;
      clk_d         = (state_d == ST_SHIFT_HI);
      lat_d         = (state_d == ST_LATCH);
      oe_d          = !(shifting_c && shown_d);
      abc_d         = latch_entry_c ? row_q : abc_q;
      fs_d          = latch_entry_c && (row_q == '0);
      rd_addr_d     = rd_addr_q;
      if ((state_d == ST_SHIFT_LO) && (state_q != ST_SHIFT_LO)) begin
         rd_addr_d = {row_d, col_d};
      end
      pix_d = pix_q;
      if ((state_q == ST_SHIFT_LO) && (phase == '0)) begin
         pix_d = pix_c;
      end
   end

   always_ff @(posedge Clkin) begin
      if (Rstin) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         shown_q   <= 1'b0;
         rd_addr_q <= '0;
         pix_q     <= '0;
         clk_q     <= 1'b0;
         lat_q     <= 1'b0;
         oe_q      <= 1'b1;
         abc_q     <= '0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         shown_q   <= shown_d;
         rd_addr_q <= rd_addr_d;
         pix_q     <= pix_d;
         clk_q     <= clk_d;
         lat_q     <= lat_d;
         oe_q      <= oe_d;
         abc_q     <= abc_d;
         fs_q      <= fs_d;
      end
   end

   assign rd_addr     = rd_addr_q;
   assign R1          = pix_q[R1_BIT];
   assign G1          = pix_q[G1_BIT];
   assign B1          = pix_q[B1_BIT];
   assign R2          = pix_q[R2_BIT];
   assign G2          = pix_q[G2_BIT];
   assign B2          = pix_q[B2_BIT];
   assign Clk         = clk_q;
   assign Lat         = lat_q;
   assign OE          = oe_q;
   assign A           = abc_q[0];
   assign B           = abc_q[1];
   assign C           = abc_q[2];
   assign frame_start = fs_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: reset/idle, constant and address-derived
// pixel data, en drop mid-frame and reset mid-row, against hand-derived cycle numbers.
module tb_hub75_scan_ctrl;

   logic       Clkin = 1'b0;
   logic       Rstin = 1'b1;
   logic       en    = 1'b0;
   logic [7:0] rd_addr;
   logic [5:0] rd_data;
   logic       R1, G1, B1, R2, G2, B2, Clk, Lat, OE, A, B, C, frame_start;
   logic       mode = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic pclk, plat;

   localparam logic [20:0] RST_VEC = {6'b0, 1'b0, 1'b0, 1'b1, 3'b0, 1'b0, 8'h00};

   hub75_scan_ctrl dut (
      .Clkin(Clkin), .Rstin(Rstin), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
      .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
      .Clk(Clk), .Lat(Lat), .OE(OE), .A(A), .B(B), .C(C), .frame_start(frame_start)
   );

   always #5 Clkin = ~Clkin;

   // Combinational frame-buffer model
   assign rd_data = (mode == 1'b0) ? 6'b101010 : rd_addr[5:0];

   // Cycle 0 is the cycle following the last posedge that samples Rstin high
   always @(posedge Clkin) begin
      if (Rstin) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   wire [5:0]  pix_o   = {R1, G1, B1, R2, G2, B2};
   wire [2:0]  abc_o   = {C, B, A};
   wire [20:0] out_vec = {pix_o, Clk, Lat, OE, abc_o, frame_start, rd_addr};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [5:0] exp_pix(input logic m, input logic [2:0] r, input logic [4:0] c);
`ifdef SCAN_TESTPAT_EN
      logic b;
      b = ({2'b00, r} == c);
      return {c[0], r[0], b, c[0], r[0], b} | {5'b0, m & 1'b0};
`else
      if (m == 1'b0) return 6'b101010;
      return {r[0], c};
`endif
   endfunction

   task automatic tick();
      pclk = Clk;
      plat = Lat;
      @(negedge Clkin);
   endtask

   task automatic do_reset(input logic en_val);
      Rstin = 1'b1;
      en    = en_val;
      repeat (5) @(negedge Clkin);
      Rstin = 1'b0;
   endtask

   initial begin
      int rises, first_rise, bad, oe_low, lat_first, lat_hi, lat_last, fs_cnt, fs_cyc;
      int lat_cnt, abc_bad, lat_cyc, got_lat;
      int fs_at[4];
      logic [4:0] ecol;
      logic [2:0] lat_abc;

      // Reset held, then idle with en low
      do_reset(1'b0);
      check("reset_outputs", 32'(out_vec), 32'(RST_VEC));
      rises = 0; bad = 0; oe_low = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (Clk && !pclk) rises++;
         if (!OE) oe_low++;
         if (out_vec !== RST_VEC) bad++;
      end
      check("idle_clk_rises", 32'(rises), 32'd0);
      check("idle_oe_low", 32'(oe_low), 32'd0);
      check("idle_outputs", 32'(bad), 32'd0);

      // Constant pixel data, first row timing
      mode = 1'b0;
      do_reset(1'b1);
      rises = 0; first_rise = -1; bad = 0; oe_low = 0; lat_first = -1; lat_hi = 0;
      lat_last = -1; fs_cnt = 0; fs_cyc = -1; ecol = '0; lat_abc = 3'h7;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (cyc == 1) check("pix_before_fetch", 32'(pix_o), 32'd0);
         if (cyc == 2) check("pix_first_valid", 32'(pix_o), 32'(exp_pix(1'b0, 3'd0, 5'd0)));
         if (Clk && !pclk) begin
            if (first_rise < 0) first_rise = cyc;
            if (cyc <= 384) rises++;
            if (pix_o !== exp_pix(1'b0, 3'd0, ecol)) bad++;
            ecol = ecol + 5'd1;
         end
         if (Lat) begin
            if (lat_first < 0) begin
               lat_first = cyc;
               lat_abc   = abc_o;
            end
            lat_hi++;
            lat_last = cyc;
         end
         if (frame_start) begin
            fs_cnt++;
            fs_cyc = cyc;
         end
         if (cyc <= 396 && !OE) oe_low++;
         if (cyc == 397) check("oe_on_after_latch", 32'(OE), 32'd0);
      end
      check("first_clk_rise", 32'(first_rise), 32'd7);
      check("row_clk_rises", 32'(rises), 32'd32);
      check("const_pix_at_rise", 32'(bad), 32'd0);
      check("lat_first", 32'(lat_first), 32'd391);
      check("lat_high_cycles", 32'(lat_hi), 32'd6);
      check("lat_last", 32'(lat_last), 32'd396);
      check("row0_abc", 32'(lat_abc), 32'd0);
      check("fs_count_row0", 32'(fs_cnt), 32'd1);
      check("fs_cycle_row0", 32'(fs_cyc), 32'd391);
      check("oe_blank_first_row", 32'(oe_low), 32'd0);

      // Address-derived data over two frames
      mode = 1'b1;
      do_reset(1'b1);
      rises = 0; bad = 0; lat_cnt = 0; abc_bad = 0; fs_cnt = 0; ecol = '0;
      while (cyc < 6730) begin
         tick();
         if (Clk && !pclk) begin
            rises++;
            if (pix_o !== exp_pix(1'b1, 3'(lat_cnt), ecol)) bad++;
            ecol = ecol + 5'd1;
         end
         if (Lat && !plat) begin
            if (abc_o !== 3'(lat_cnt)) abc_bad++;
            if (lat_cnt == 8) check("abc_wrap", 32'(abc_o), 32'd0);
            lat_cnt++;
         end
         if (frame_start) begin
            if (fs_cnt < 4) fs_at[fs_cnt] = cyc;
            fs_cnt++;
         end
      end
      check("frame_pix_at_rise", 32'(bad), 32'd0);
      check("frame_clk_rises", 32'(rises), 32'd544);
      check("frame_latches", 32'(lat_cnt), 32'd17);
      check("frame_abc_seq", 32'(abc_bad), 32'd0);
      check("fs_count", 32'(fs_cnt), 32'd3);
      if (fs_cnt == 3) begin
         check("fs_first", 32'(fs_at[0]), 32'd391);
         check("fs_period_1", 32'(fs_at[1] - fs_at[0]), 32'd3168);
         check("fs_period_2", 32'(fs_at[2] - fs_at[1]), 32'd3168);
      end

      // Drop en during row 3, then resume
      do_reset(1'b1);
      while (cyc < 1300) tick();
      en = 1'b0;
      lat_cnt = 0; lat_cyc = -1; lat_abc = 3'h7; rises = 0; oe_low = 0;
      while (cyc < 1800) begin
         tick();
         if (Lat && !plat) begin
            lat_cnt++;
            lat_cyc = cyc;
            lat_abc = abc_o;
         end
         if (cyc >= 1585 && Clk && !pclk) rises++;
         if (cyc >= 1585 && !OE) oe_low++;
      end
      check("drop_lat_count", 32'(lat_cnt), 32'd1);
      check("drop_lat_cycle", 32'(lat_cyc), 32'd1579);
      check("drop_lat_abc", 32'(lat_abc), 32'd3);
      check("drop_idle_rises", 32'(rises), 32'd0);
      check("drop_idle_oe", 32'(oe_low), 32'd0);
      en = 1'b1;
      tick();
      check("resume_rd_addr", 32'(rd_addr), 32'h80);
      got_lat = 0;
      for (int i = 0; i < 500 && got_lat == 0; i++) begin
         tick();
         if (Lat && !plat) begin
            got_lat = 1;
            check("resume_lat_cycle", 32'(cyc), 32'd2191);
            check("resume_lat_abc", 32'(abc_o), 32'd4);
         end
      end
      check("resume_lat_seen", 32'(got_lat), 32'd1);

      // Reset 200 cycles into row 1
      do_reset(1'b1);
      while (cyc < 597) tick();
      Rstin = 1'b1;
      tick();
      check("midreset_outputs", 32'(out_vec), 32'(RST_VEC));
      Rstin = 1'b0;
      tick();
      check("restart_rd_addr", 32'(rd_addr), 32'h00);
      got_lat = 0;
      for (int i = 0; i < 600 && got_lat == 0; i++) begin
         tick();
         if (cyc == 100) check("restart_oe_blank", 32'(OE), 32'd1);
         if (Lat && !plat) begin
            got_lat = 1;
            check("restart_lat_cycle", 32'(cyc), 32'd391);
            check("restart_lat_abc", 32'(abc_o), 32'd0);
         end
      end
      check("restart_lat_seen", 32'(got_lat), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
